multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Control FSM that sequences the RV32I multicycle datapath: instruction decoder, register file,
//  ALU, PC and memory ports. Steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
//  Produces per-state strobes and datapath selects, counts retired instructions, and
//  traps on illegal opcodes, ECALL/EBREAK or memory timeout.
// PARAMETERS
//  CNT_W        32   width of retired-instruction counter instrCount
//  MEM_TIMEOUT  255  max cycles waiting for imemReady/dmemReady before trap (>=2)
// PORTS
//  clk          in   1      clock, rising edge
//  rst_n        in   1      asynchronous active-low reset
//  opcode       in   7      instr[6:0] from IR; valid from DECODE onward
//  imemReady    in   1      instruction memory done; IR input valid this cycle
//  dmemReady    in   1      data memory access done this cycle
//  branchTaken  in   1      ALU branch-compare result, valid in EXEC
//  imemReq      out  1      fetch request
//  irWrite      out  1      load IR this edge
//  pcWrite      out  1      update PC this edge
//  pcSrc        out  2      0 pc+4, 1 pc+imm (branch/JAL), 2 rs1+imm (JALR)
//  aluASel      out  1      0 rs1, 1 pc
//  aluBSel      out  1      0 rs2, 1 imm
//  dmemRead     out  1      load request
//  dmemWrite    out  1      store request
//  regWrite     out  1      register-file write enable
//  wbSel        out  2      0 ALU, 1 mem data, 2 pc+4, 3 imm
//  trap         out  1      FSM halted in TRAP
//  trapCause    out  2      0 none, 1 illegal opcode, 2 ECALL/EBREAK, 3 memory timeout
//  state        out  3      IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5 TRAP=7
//  instrCount   out  CNT_W  retired instructions
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, opReg=0, timeout counter=0, instrCount=0, trapCause=0.
//   All outputs 0 while in reset and in IDLE. Pending memory requests drop combinationally.
//  Outputs: combinational from state and opReg. opReg latches opcode on the DECODE->EXEC edge.
//  IDLE->FETCH unconditionally on the first edge after rst_n rises.
//  FETCH: imemReq=1. irWrite=imemReady. imemReady=1 -> DECODE.
//  DECODE: no strobes. Branch on opcode:
//   - legal OP, OP-IMM, LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, FENCE -> EXEC
//   - 1110011 -> TRAP, cause 2
//   - any other value -> TRAP, cause 1
//  EXEC: selects driven from opReg.
//   - aluASel=1 for AUIPC and JAL.
//   - aluBSel=1 for OP-IMM, LOAD, STORE, JALR, AUIPC, JAL, LUI.
//   - BRANCH: pcWrite=1, pcSrc=branchTaken?1:0, ->FETCH.
//   - FENCE: pcWrite=1, pcSrc=0, ->FETCH.
//   - LOAD/STORE ->MEM. Others ->WB.
//  MEM: dmemRead (LOAD) or dmemWrite (STORE) held until dmemReady.
//   - On dmemReady, LOAD ->WB.
//   - On dmemReady, STORE asserts pcWrite=1, pcSrc=0, ->FETCH.
//  WB: regWrite=1, wbSel (LOAD 1, JAL/JALR 2, LUI 3, else 0), pcWrite=1 with pcSrc
//   (JAL 1, JALR 2, else 0), ->FETCH.
//  aluASel/aluBSel/wbSel hold their opReg-derived values through EXEC, MEM and WB.
//   They are 0 in the other states.
//  instrCount: +1 on every cycle with pcWrite=1; wraps modulo 2^CNT_W.
//  Timeout counter: cleared on entry to FETCH/MEM; +1 each FETCH/MEM cycle with ready low.
//   Ready low while counter==MEM_TIMEOUT-1 -> TRAP, cause 3. Ready in that cycle wins (no trap).
//  TRAP: absorbing until reset. trap=1, trapCause held, all strobes/selects 0.
//   instrCount frozen.
//  Latency at zero wait states: ALU/LUI/AUIPC/JAL/JALR 4 cycles, LOAD 5, STORE 4,
//   BRANCH/FENCE 3.
// TESTING
//  1. rst_n rise, imemReady=1, opcode=0110011
//     -> states 0,1,2,3,5,1; regWrite=1/wbSel=0 only in WB; instrCount=1 after WB edge.
//  2. opcode=0000011, dmemReady low 3 MEM cycles then high
//     -> dmemRead high 4 cycles, WB wbSel=1, instrCount+1.
//  3. opcode=1100011, branchTaken=1
//     -> EXEC pcWrite=1 pcSrc=1, next state FETCH, regWrite never asserted.
//     Repeat with branchTaken=0 -> pcSrc=0.
//  4. opcode=0000000 -> DECODE->TRAP, trap=1 trapCause=1, imemReq=0 for 20 cycles,
//     cleared by rst_n. opcode=1110011 -> trapCause=2.
//  5. MEM_TIMEOUT=8, imemReady low -> TRAP cause 3 on the edge ending the 8th FETCH cycle.
//     imemReady high on the 8th cycle -> DECODE, no trap.
//  6. rst_n low mid-MEM of a STORE -> dmemWrite=0 before next edge, state=0, instrCount=0.
//     Release -> normal fetch resumes.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Control FSM for the RV32I multicycle datapath.
// It walks each instruction through FETCH, DECODE, EXEC, MEM and WB.
// It drives the datapath strobes and selects and counts retired
// instructions. It halts in TRAP on an illegal opcode, on ECALL/EBREAK,
// or when a memory port stays not-ready for too long.
// Ports:
//   clk, rst_n                    clock; async active-low reset
//   opcode                        instr[6:0] from the IR
//   imemReady, dmemReady          memory handshakes
//   branchTaken                   branch compare result from the ALU
//   imemReq, irWrite, pcWrite     fetch request, IR load, PC load
//   pcSrc, aluASel, aluBSel       PC source and ALU operand selects
//   dmemRead, dmemWrite           data memory requests
//   regWrite, wbSel               register write enable, writeback source
//   trap, trapCause, state        halt status and current FSM state
//   instrCount                    retired-instruction counter
module multicycle_ctrl #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic             imemReady,
    input  logic             dmemReady,
    input  logic             branchTaken,
    output logic             imemReq,
    output logic             irWrite,
    output logic             pcWrite,
    output logic [1:0]       pcSrc,
    output logic             aluASel,
    output logic             aluBSel,
    output logic             dmemRead,
    output logic             dmemWrite,
    output logic             regWrite,
    output logic [1:0]       wbSel,
    output logic             trap,
    output logic [1:0]       trapCause,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instrCount
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd7
    } state_e;

    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // Wide enough to hold MEM_TIMEOUT-1.
    localparam int TW = $clog2(MEM_TIMEOUT) + 1;

    state_e            state_q, state_d;
    logic [6:0]        opReg_q;
    logic [TW-1:0]     tmo_q;
    logic [1:0]        cause_q, cause_d;
    logic [CNT_W-1:0]  cnt_q;

    logic is_op, is_opimm, is_lui, is_auipc, is_jal, is_jalr;
    logic is_br, is_ld, is_st, is_fence;
    logic legal;
    logic waiting, tmo_hit;

    assign is_op    = (opReg_q == OP_OP);
    assign is_opimm = (opReg_q == OP_OPIMM);
    assign is_lui   = (opReg_q == OP_LUI);
    assign is_auipc = (opReg_q == OP_AUIPC);
    assign is_jal   = (opReg_q == OP_JAL);
    assign is_jalr  = (opReg_q == OP_JALR);
    assign is_br    = (opReg_q == OP_BRANCH);
    assign is_ld    = (opReg_q == OP_LOAD);
    assign is_st    = (opReg_q == OP_STORE);
    assign is_fence = (opReg_q == OP_FENCE);

    // Legality is judged on the live IR opcode during DECODE.
    always_comb begin
        legal = 1'b0;
        case (opcode)
            OP_OP, OP_OPIMM, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
            OP_BRANCH, OP_LOAD, OP_STORE, OP_FENCE: legal = 1'b1;
            default: legal = 1'b0;
        endcase
    end

    // A ready arriving in the last allowed cycle still wins over the trap.
    assign waiting = ((state_q == S_FETCH) && !imemReady)
                  || ((state_q == S_MEM) && !dmemReady);
    assign tmo_hit = waiting && (tmo_q == TW'(MEM_TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        unique case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                if (imemReady) begin
                    state_d = S_DECODE;
                end else if (tmo_hit) begin
                    state_d = S_TRAP;
                    cause_d = 2'd3;
                end
            end
            S_DECODE: begin
                if (legal) begin
                    state_d = S_EXEC;
                end else if (opcode == OP_SYSTEM) begin
                    state_d = S_TRAP;
                    cause_d = 2'd2;
                end else begin
                    state_d = S_TRAP;
                    cause_d = 2'd1;
                end
            end
            S_EXEC: begin
                if (is_br || is_fence) state_d = S_FETCH;
                else if (is_ld || is_st) state_d = S_MEM;
                else state_d = S_WB;
            end
            S_MEM: begin
                if (dmemReady) begin
                    state_d = is_ld ? S_WB : S_FETCH;
                end else if (tmo_hit) begin
                    state_d = S_TRAP;
                    cause_d = 2'd3;
                end
            end
            S_WB:   state_d = S_FETCH;
            S_TRAP: state_d = S_TRAP;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        imemReq   = 1'b0;
        irWrite   = 1'b0;
        pcWrite   = 1'b0;
        pcSrc     = 2'd0;
        aluASel   = 1'b0;
        aluBSel   = 1'b0;
        dmemRead  = 1'b0;
        dmemWrite = 1'b0;
        regWrite  = 1'b0;
        wbSel     = 2'd0;
        // The operand and writeback selects stay stable from EXEC to WB.
        if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
            aluASel = is_auipc | is_jal;
            aluBSel = is_opimm | is_ld | is_st | is_jalr
                    | is_auipc | is_jal | is_lui;
            if (is_ld) wbSel = 2'd1;
            else if (is_jal || is_jalr) wbSel = 2'd2;
            else if (is_lui) wbSel = 2'd3;
        end
        unique case (state_q)
            S_FETCH: begin
                imemReq = 1'b1;
                irWrite = imemReady;
            end
            S_EXEC: begin
                if (is_br) begin
                    pcWrite = 1'b1;
                    pcSrc   = branchTaken ? 2'd1 : 2'd0;
                end else if (is_fence) begin
                    pcWrite = 1'b1;
                end
            end
            S_MEM: begin
                dmemRead  = is_ld;
                dmemWrite = is_st;
                if (is_st && dmemReady) pcWrite = 1'b1;
            end
            S_WB: begin
                regWrite = 1'b1;
                pcWrite  = 1'b1;
                if (is_jal) pcSrc = 2'd1;
                else if (is_jalr) pcSrc = 2'd2;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            opReg_q <= 7'd0;
            tmo_q   <= '0;
            cause_q <= 2'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            if (state_q == S_DECODE && state_d == S_EXEC) opReg_q <= opcode;
            // Any state change clears the wait counter, covering entry
            // into FETCH and MEM.
            if (state_d != state_q) tmo_q <= '0;
            else if (waiting) tmo_q <= tmo_q + TW'(1);
            if (pcWrite) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign trap       = (state_q == S_TRAP);
    assign trapCause  = cause_q;
    assign state      = state_q;
    assign instrCount = cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed testbench for multicycle_ctrl.
// Inputs change on the falling edge, and outputs are checked there too.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  opcode;
    logic        imemReady, dmemReady, branchTaken;
    logic        imemReq, irWrite, pcWrite;
    logic [1:0]  pcSrc;
    logic        aluASel, aluBSel, dmemRead, dmemWrite, regWrite;
    logic [1:0]  wbSel;
    logic        trap;
    logic [1:0]  trapCause;
    logic [2:0]  state;
    logic [31:0] instrCount;

    int errors = 0;
    int checks = 0;

    multicycle_ctrl #(.CNT_W(32), .MEM_TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode),
        .imemReady(imemReady), .dmemReady(dmemReady),
        .branchTaken(branchTaken), .imemReq(imemReq),
        .irWrite(irWrite), .pcWrite(pcWrite), .pcSrc(pcSrc),
        .aluASel(aluASel), .aluBSel(aluBSel), .dmemRead(dmemRead),
        .dmemWrite(dmemWrite), .regWrite(regWrite), .wbSel(wbSel),
        .trap(trap), .trapCause(trapCause), .state(state),
        .instrCount(instrCount)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    int n;

    initial begin
        rst_n = 1'b0; opcode = 7'd0;
        imemReady = 1'b0; dmemReady = 1'b0; branchTaken = 1'b0;
        cyc(); cyc();
        chk("rst_state", 32'(state), 0);
        chk("rst_imemReq", 32'(imemReq), 0);
        chk("rst_cnt", instrCount, 0);
        chk("rst_trap", 32'(trap), 0);

        // 1: R-type ALU instruction
        rst_n = 1'b1; imemReady = 1'b1; opcode = 7'b0110011;
        cyc();
        chk("t1_fetch", 32'(state), 1);
        chk("t1_imemReq", 32'(imemReq), 1);
        chk("t1_irWrite", 32'(irWrite), 1);
        cyc();
        chk("t1_decode", 32'(state), 2);
        chk("t1_dec_regW", 32'(regWrite), 0);
        cyc();
        chk("t1_exec", 32'(state), 3);
        chk("t1_exec_regW", 32'(regWrite), 0);
        chk("t1_exec_bsel", 32'(aluBSel), 0);
        cyc();
        chk("t1_wb", 32'(state), 5);
        chk("t1_wb_regW", 32'(regWrite), 1);
        chk("t1_wb_wbSel", 32'(wbSel), 0);
        chk("t1_wb_pcW", 32'(pcWrite), 1);
        chk("t1_wb_cnt", instrCount, 0);
        cyc();
        chk("t1_refetch", 32'(state), 1);
        chk("t1_cnt", instrCount, 1);

        // 2: LOAD with three MEM wait cycles
        opcode = 7'b0000011;
        n = 0;
        cyc();
        cyc();
        chk("t2_exec_bsel", 32'(aluBSel), 1);
        cyc();
        if (dmemRead) n++;
        cyc();
        if (dmemRead) n++;
        cyc();
        if (dmemRead) n++;
        cyc();
        dmemReady = 1'b1;
        if (dmemRead) n++;
        chk("t2_mem_state", 32'(state), 4);
        cyc();
        chk("t2_read_cycles", n, 4);
        chk("t2_wb", 32'(state), 5);
        chk("t2_wbSel", 32'(wbSel), 1);
        chk("t2_dmemRead_wb", 32'(dmemRead), 0);
        cyc();
        dmemReady = 1'b0;
        chk("t2_cnt", instrCount, 2);

        // 3: branch taken, then not taken
        opcode = 7'b1100011; branchTaken = 1'b1;
        cyc();
        cyc();
        chk("t3_exec_pcW", 32'(pcWrite), 1);
        chk("t3_exec_pcSrc", 32'(pcSrc), 1);
        chk("t3_exec_regW", 32'(regWrite), 0);
        cyc();
        chk("t3_fetch", 32'(state), 1);
        chk("t3_cnt", instrCount, 3);
        branchTaken = 1'b0;
        cyc();
        cyc();
        chk("t3_nt_pcSrc", 32'(pcSrc), 0);
        chk("t3_nt_pcW", 32'(pcWrite), 1);
        cyc();
        chk("t3_nt_fetch", 32'(state), 1);
        chk("t3_nt_cnt", instrCount, 4);

        // JAL
        opcode = 7'b1101111;
        cyc();
        cyc();
        chk("jal_asel", 32'(aluASel), 1);
        chk("jal_bsel", 32'(aluBSel), 1);
        cyc();
        chk("jal_wbSel", 32'(wbSel), 2);
        chk("jal_pcSrc", 32'(pcSrc), 1);
        chk("jal_asel_wb", 32'(aluASel), 1);
        cyc();
        chk("jal_cnt", instrCount, 5);

        // 4: illegal opcode, then ECALL
        opcode = 7'b0000000;
        cyc();
        cyc();
        chk("t4_trap_state", 32'(state), 7);
        chk("t4_trap", 32'(trap), 1);
        chk("t4_cause", 32'(trapCause), 1);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (imemReq || pcWrite || state != 3'd7) n++;
        end
        chk("t4_absorbing", n, 0);
        chk("t4_cnt_frozen", instrCount, 5);
        rst_n = 1'b0;
        #1;
        chk("t4_rst_state", 32'(state), 0);
        chk("t4_rst_trap", 32'(trap), 0);
        chk("t4_rst_cause", 32'(trapCause), 0);
        chk("t4_rst_cnt", instrCount, 0);
        cyc();
        rst_n = 1'b1; opcode = 7'b1110011;
        cyc();
        cyc();
        cyc();
        chk("t4_ecall_state", 32'(state), 7);
        chk("t4_ecall_cause", 32'(trapCause), 2);

        // 5: fetch timeout with MEM_TIMEOUT=8
        rst_n = 1'b0;
        cyc();
        imemReady = 1'b0; rst_n = 1'b1;
        cyc();
        for (int i = 0; i < 7; i++) cyc();
        chk("t5_fetch8", 32'(state), 1);
        cyc();
        chk("t5_trap_state", 32'(state), 7);
        chk("t5_cause", 32'(trapCause), 3);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
        for (int i = 0; i < 7; i++) cyc();
        imemReady = 1'b1; opcode = 7'b0001111;
        cyc();
        chk("t5_late_ready", 32'(state), 2);
        chk("t5_no_trap", 32'(trap), 0);
        cyc();
        chk("t5_fence_pcW", 32'(pcWrite), 1);
        cyc();
        chk("t5_fence_cnt", instrCount, 1);

        // 6: reset in the middle of a STORE
        opcode = 7'b0100011;
        cyc();
        cyc();
        cyc();
        chk("t6_mem_state", 32'(state), 4);
        chk("t6_dmemWrite", 32'(dmemWrite), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_dmemWrite", 32'(dmemWrite), 0);
        chk("t6_rst_state", 32'(state), 0);
        chk("t6_rst_cnt", instrCount, 0);
        cyc();
        rst_n = 1'b1; dmemReady = 1'b1;
        cyc();
        chk("t6_fetch", 32'(state), 1);
        chk("t6_imemReq", 32'(imemReq), 1);
        cyc();
        cyc();
        cyc();
        chk("t6_st_write", 32'(dmemWrite), 1);
        chk("t6_st_pcW", 32'(pcWrite), 1);
        cyc();
        chk("t6_st_fetch", 32'(state), 1);
        chk("t6_st_cnt", instrCount, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
